sme_hash_lookup: RTL

- Front-end lookup stage of the Pigasus string-matching engine; sits directly upstream of the dual-port rule ROM (rom_2port, 1-cycle registered read).
- Accepts two 32-bit packet-window keys per beat and computes a two-term multiplicative hash for each, using the same registered multiply-add form as the dsp block.
- Drives ROM port A and port B addresses, re-aligns the returned rule words with their keys, and buffers results in an output FIFO under a valid/ready handshake.
- The ROM has no enable, so backpressure is handled by credit-based admission, never by stalling the pipeline.

---
 rtl/sme_hash_lookup_pkg.sv | 36 +++
 rtl/sme_hash_lookup_fifo.sv | 45 ++++
 rtl/sme_hash_lookup.sv | 104 ++++++++++
 3 files changed

// File: rtl/sme_hash_lookup_pkg.sv
// Shared hash constants, reference hash functions and the lookup result record
// for the string-matching front end.
package sme_pkg;

  localparam int          HASH_SUM_W  = 37;
  localparam logic [17:0] MULT_LO_DEF = 18'h1F3A5;
  localparam logic [17:0] MULT_HI_DEF = 18'h2C6B1;
  localparam int          RULE_W      = 16;
  localparam int          TAG_W       = 8;

  typedef struct packed {
    logic [RULE_W-1:0] rule_a;
    logic [RULE_W-1:0] rule_b;
    logic [1:0]        hit;
    logic [TAG_W-1:0]  tag;
  } lookup_res_t;

  // Two-term multiply-add, same shape as the DSP block: lo*MULT_LO + hi*MULT_HI.
  function automatic logic [HASH_SUM_W-1:0] hash_sum(input logic [31:0] key,
                                                     input logic [17:0] mlo,
                                                     input logic [17:0] mhi);
    logic [HASH_SUM_W-1:0] lo, hi;
    lo = {21'b0, key[15:0]}  * {19'b0, mlo};
    hi = {21'b0, key[31:16]} * {19'b0, mhi};
    return lo + hi;
  endfunction

  // Caller keeps the low AWIDTH bits of the result.
  function automatic logic [HASH_SUM_W-1:0] hash_addr(input logic [31:0] key,
                                                      input int unsigned shift,
                                                      input logic [17:0] mlo,
                                                      input logic [17:0] mhi);
    return hash_sum(key, mlo, mhi) >> shift;
  endfunction

endpackage

// File: rtl/sme_hash_lookup_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; head word is visible
// combinationally whenever count is non-zero.
module sme_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp, rp;
  logic             rd;

  assign rd      = rd_en && (count != '0);
  assign rd_data = mem[rp];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= wr_data;
  end

  // Pointers are exactly PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd)    rp <= rp + 1'b1;
      case ({wr_en, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sme_hash_lookup.sv
// Two-lane hash lookup in front of the dual-port rule ROM: hash, address, realign
// the ROM words with their beat, and buffer results under credit-based admission.
module sme_hash_lookup
  import sme_pkg::*;
#(
  parameter int          AWIDTH      = 12,
  parameter int          DWIDTH      = 16,
  parameter int          TAG_WIDTH   = 8,
  parameter logic [17:0] MULT_LO     = MULT_LO_DEF,
  parameter logic [17:0] MULT_HI     = MULT_HI_DEF,
  parameter int          HASH_SHIFT  = 16,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          FILTER_MISS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          in_key_a,
  input  logic [31:0]          in_key_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [AWIDTH-1:0]    rom_addr_a,
  output logic [AWIDTH-1:0]    rom_addr_b,
  input  logic [DWIDTH-1:0]    rom_q_a,
  input  logic [DWIDTH-1:0]    rom_q_b,
  output logic [DWIDTH-1:0]    out_rule_a,
  output logic [DWIDTH-1:0]    out_rule_b,
  output logic [1:0]           out_hit,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_valid,
  input  logic                 out_ready
);
  localparam int NUM_LANES = 2;
  // S0, S1, S2, ROM read cycle, S3
  localparam int STAGES    = 4;
  localparam int CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int FW        = 2*DWIDTH + 2 + TAG_WIDTH;

  logic [STAGES:0]                             vld_pipe;
  logic [STAGES:0][TAG_WIDTH-1:0]              tag_pipe;
  logic [NUM_LANES-1:0][31:0]                  key_s0;
  logic [NUM_LANES-1:0][HASH_SUM_W-1:0]        sum_s1;
  logic [NUM_LANES-1:0][AWIDTH-1:0]            addr_s2;
  logic [NUM_LANES-1:0][DWIDTH-1:0]            rule_s3;
  logic [1:0]                                  hit_s3;
  logic                                        accept, fifo_wr;
  logic [2:0]                                  inflight;
  logic [CW-1:0]                               fifo_count;
  logic [CW:0]                                 occ;
  logic [FW-1:0]                               head;
  logic                                        unused_sum;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      addr_s2  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], accept};
      for (int i = 0; i < NUM_LANES; i++)
        addr_s2[i] <= sum_s1[i][HASH_SHIFT +: AWIDTH];
    end
  end

  // Data stages free-run; only the valid bits decide what reaches the FIFO.
  always_ff @(posedge clk) begin
    tag_pipe <= {tag_pipe[STAGES-1:0], in_tag};
    key_s0   <= {in_key_b, in_key_a};
    rule_s3  <= {rom_q_b, rom_q_a};
    for (int i = 0; i < NUM_LANES; i++)
      sum_s1[i] <= hash_sum(key_s0[i], MULT_LO, MULT_HI);
  end

  assign unused_sum = ^sum_s1;
  assign rom_addr_a = addr_s2[0];
  assign rom_addr_b = addr_s2[1];

  assign hit_s3  = {|rule_s3[1], |rule_s3[0]};
  assign fifo_wr = vld_pipe[STAGES] && ((FILTER_MISS == 0) || (|hit_s3));

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= STAGES; i++) inflight = inflight + {2'b0, vld_pipe[i]};
  end

  // Every admitted beat holds a FIFO slot until it is popped or filtered out.
  assign occ      = {1'b0, fifo_count} + (CW+1)'(inflight);
  assign in_ready = !rst && (occ < (CW+1)'(FIFO_DEPTH));

  sme_sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data ({rule_s3[1], rule_s3[0], hit_s3, tag_pipe[STAGES]}),
    .rd_en   (out_ready),
    .rd_data (head),
    .count   (fifo_count)
  );

  assign {out_rule_b, out_rule_a, out_hit, out_tag} = head;
  assign out_valid = (fifo_count != '0);

endmodule
